muldiv_control_sequencer: RTL and testbench

Hardwired control sequencer for the MUL/DIV instruction class. It drives the datapath control strobes (PCout, Zlowout, Zhighout, MDRout, register out/in, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, read, MUL, DIV) through fetch T0–T2 and execute T3–T6. It replaces the hand-scripted stimulus currently used to exercise the datapath. It sits beside the datapath, reads the loaded IR back, and handshakes with memory (`mem_rdy`) and the multi-cycle multiplier/divider (`alu_done`).

---
 rtl/muldiv_control_sequencer.sv | 175 +++++++++++++++++
 tb/tb_muldiv_control_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_control_sequencer.sv
// Hardwired Moore sequencer for MUL/DIV: fetch (T0-T2), decode (T3), wait on the
// multiplier/divider (T4), then write LO/HI (T5/T6). Aborts on bad opcode or ALU timeout.
module muldiv_control_sequencer #(
   parameter logic [4:0]  OP_MUL   = 5'b01000,
   parameter logic [4:0]  OP_DIV   = 5'b01001,
   parameter int unsigned MAX_WAIT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] ir_in,
   input  logic        mem_rdy,
   input  logic        alu_done,
   output logic        busy,
   output logic        done,
   output logic        illegal_op,
   output logic        timeout,
   output logic        PCout,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        MDRout,
   output logic        MARin,
   output logic        Zin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        HIin,
   output logic        LOin,
   output logic        IncPC,
   output logic        read,
   output logic        MUL,
   output logic        DIV,
   output logic [15:0] r_out
);

   localparam int             CW       = $clog2(MAX_WAIT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_WAIT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_ABORT
   } state_e;

   state_e        state_q, state_d;
   logic [4:0]    opcode_q, opcode_d;
   logic [3:0]    rc_q, rc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_q, tmo_d;   // abort reason: 1 = ALU timeout, 0 = illegal opcode

   logic          unused_ir_bits;
   assign unused_ir_bits = ^{ir_in[26:23], ir_in[14:0]};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         opcode_q <= '0;
         rc_q     <= '0;
         cnt_q    <= '0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         rc_q     <= rc_d;
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
      end
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      opcode_d   = opcode_q;
      rc_d       = rc_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      busy       = (state_q != S_IDLE);
      done       = 1'b0;
      illegal_op = 1'b0;
      timeout    = 1'b0;
      PCout      = 1'b0;
      Zlowout    = 1'b0;
      Zhighout   = 1'b0;
      MDRout     = 1'b0;
      MARin      = 1'b0;
      Zin        = 1'b0;
      PCin       = 1'b0;
      MDRin      = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      HIin       = 1'b0;
      LOin       = 1'b0;
      IncPC      = 1'b0;
      read       = 1'b0;
      MUL        = 1'b0;
      DIV        = 1'b0;
      r_out      = '0;

      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_T0;
         end
         S_T0: begin
            PCout   = 1'b1;
            MARin   = 1'b1;
            IncPC   = 1'b1;
            Zin     = 1'b1;
            state_d = S_T1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            read    = 1'b1;
            MDRin   = 1'b1;
            state_d = mem_rdy ? S_T2 : S_T1W;
         end
         S_T1W: begin
            read  = 1'b1;
            MDRin = 1'b1;
            if (mem_rdy) state_d = S_T2;
         end
         S_T2: begin
            MDRout  = 1'b1;
            IRin    = 1'b1;
            state_d = S_T3;
         end
         S_T3: begin
            // IR was loaded at the end of T2, so ir_in is already stable here.
            r_out    = 16'(1) << ir_in[22:19];
            Yin      = 1'b1;
            opcode_d = ir_in[31:27];
            rc_d     = ir_in[18:15];
            cnt_d    = '0;
            if (ir_in[31:27] == OP_MUL || ir_in[31:27] == OP_DIV) begin
               state_d = S_T4;
            end else begin
               tmo_d   = 1'b0;
               state_d = S_ABORT;
            end
         end
         S_T4: begin
            r_out = 16'(1) << rc_q;
            Zin   = 1'b1;
            MUL   = (opcode_q == OP_MUL);
            DIV   = (opcode_q == OP_DIV);
            cnt_d = cnt_q + CW'(1);
            if (alu_done) begin
               state_d = S_T5;
            end else if (cnt_q == CNT_LAST) begin
               tmo_d   = 1'b1;
               state_d = S_ABORT;
            end
         end
         S_T5: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
            state_d = S_T6;
         end
         S_T6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
            done     = 1'b1;
            state_d  = S_IDLE;
         end
         S_ABORT: begin
            timeout    = tmo_q;
            illegal_op = ~tmo_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_muldiv_control_sequencer.sv
// Scoreboard bench: stimulus pushes the expected per-cycle strobe trace and pulse
// latency; a negedge monitor pops and compares whenever the sequencer is busy.
module tb_muldiv_control_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, mem_rdy, alu_done;
   logic [31:0] ir_in;
   logic        busy, done, illegal_op, timeout;
   logic        PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin;
   logic        IRin, Yin, HIin, LOin, IncPC, read, MUL, DIV;
   logic [15:0] r_out;

   muldiv_control_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .ir_in(ir_in), .mem_rdy(mem_rdy),
      .alu_done(alu_done), .busy(busy), .done(done), .illegal_op(illegal_op),
      .timeout(timeout), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
      .MDRout(MDRout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
      .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
      .read(read), .MUL(MUL), .DIV(DIV), .r_out(r_out)
   );

   always #5 clk = ~clk;

   localparam logic [15:0] B_PCOUT = 16'h8000, B_ZLO  = 16'h4000, B_ZHI   = 16'h2000,
                           B_MDROUT = 16'h1000, B_MARIN = 16'h0800, B_ZIN  = 16'h0400,
                           B_PCIN  = 16'h0200, B_MDRIN = 16'h0100, B_IRIN  = 16'h0080,
                           B_YIN   = 16'h0040, B_HIIN  = 16'h0020, B_LOIN  = 16'h0010,
                           B_INCPC = 16'h0008, B_READ  = 16'h0004, B_MUL   = 16'h0002,
                           B_DIV   = 16'h0001;
   localparam logic [2:0]  F_NONE = 3'b000, F_DONE = 3'b100, F_ILL = 3'b010, F_TMO = 3'b001;

   typedef struct {
      int c0;
      int lat;
      int id;
   } lat_t;

   logic [35:0] exp_q[$];
   lat_t        lat_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   bit          mon_en   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [35:0] ev(input logic [15:0] s, input logic [15:0] r,
                                      input logic [2:0] f);
      return {1'b1, s, r, f};
   endfunction

   task automatic push_n(input logic [35:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   task automatic push_fetch(input int n_wait);
      push_n(ev(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 16'h0, F_NONE), 1);
      push_n(ev(B_ZLO | B_PCIN | B_READ | B_MDRIN, 16'h0, F_NONE), 1);
      push_n(ev(B_READ | B_MDRIN, 16'h0, F_NONE), n_wait);
      push_n(ev(B_MDROUT | B_IRIN, 16'h0, F_NONE), 1);
   endtask

   task automatic push_tail();
      push_n(ev(B_ZLO | B_LOIN, 16'h0, F_NONE), 1);
      push_n(ev(B_ZHI | B_HIIN, 16'h0, F_DONE), 1);
   endtask

   // alu_k: -1 = alu_done held high throughout, 0 = never, k = high only in cycle k
   task automatic drive(input logic [31:0] ir, input int mem_low, input int alu_k,
                        input int len, input int lat, input int id);
      lat_t e;
      @(negedge clk);
      start    = 1'b1;
      ir_in    = ir;
      mem_rdy  = 1'b1;
      alu_done = (alu_k == -1);
      @(posedge clk);
      #1;
      e.c0 = cyc;
      e.lat = lat;
      e.id = id;
      lat_q.push_back(e);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         start    = 1'b0;
         mem_rdy  = !(k >= 2 && k < 2 + mem_low);
         alu_done = (alu_k == -1) || (alu_k == k);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         logic [35:0] act;
         act = {busy, PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin,
                Yin, HIin, LOin, IncPC, read, MUL, DIV, r_out, done, illegal_op, timeout};
         if (busy) begin
            if (exp_q.size() == 0) check("unexpected_busy_cycle", act, 36'h0);
            else check("strobe_trace", act, exp_q.pop_front());
         end else begin
            check("idle_outputs", act, 36'h0);
         end
         if (done || illegal_op || timeout) begin
            if (lat_q.size() == 0) begin
               check("unexpected_pulse", 64'(act[2:0]), 64'h0);
            end else begin
               lat_t e;
               e = lat_q.pop_front();
               check($sformatf("latency_%0d", e.id), 64'(cyc - e.c0 + 1), 64'(e.lat));
            end
         end
      end
   end

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      mem_rdy  = 1'b0;
      alu_done = 1'b0;
      ir_in    = 32'h0;
      repeat (3) @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // 1: DIV R2/R4, zero wait, alu_done held high (ignored outside T4)
      push_fetch(0);
      push_n(ev(B_YIN, 16'h0004, F_NONE), 1);
      push_n(ev(B_ZIN | B_DIV, 16'h0010, F_NONE), 1);
      push_tail();
      drive(32'h4A920000, 0, -1, 7, 7, 1);

      // 2: MUL back-to-back, alu_done in the 20th T4 cycle (cycle 24)
      push_fetch(0);
      push_n(ev(B_YIN, 16'h0004, F_NONE), 1);
      push_n(ev(B_ZIN | B_MUL, 16'h0010, F_NONE), 20);
      push_tail();
      drive(32'h42920000, 0, 24, 26, 26, 2);

      // 3: MUL R15/R0, mem_rdy low for 3 T1 cycles
      push_fetch(3);
      push_n(ev(B_YIN, 16'h8000, F_NONE), 1);
      push_n(ev(B_ZIN | B_MUL, 16'h0001, F_NONE), 1);
      push_tail();
      drive(32'h40780000, 3, 8, 10, 10, 3);

      // 4: illegal opcode 5'b11111
      push_fetch(0);
      push_n(ev(B_YIN, 16'h0001, F_NONE), 1);
      push_n(ev(16'h0, 16'h0, F_ILL), 1);
      drive(32'hF8000000, 0, -1, 5, 5, 4);

      // 5: DIV R7/R9, alu_done never arrives -> 64 T4 cycles then timeout
      push_fetch(0);
      push_n(ev(B_YIN, 16'h0080, F_NONE), 1);
      push_n(ev(B_ZIN | B_DIV, 16'h0200, F_NONE), 64);
      push_n(ev(16'h0, 16'h0, F_TMO), 1);
      drive(32'h483C8000, 0, 0, 69, 69, 5);

      // 6: reset in the 3rd T4 cycle; start pulsed in T2 and again alongside reset
      push_fetch(0);
      push_n(ev(B_YIN, 16'h0004, F_NONE), 1);
      push_n(ev(B_ZIN | B_MUL, 16'h0010, F_NONE), 3);
      @(negedge clk);
      start    = 1'b1;
      ir_in    = 32'h42920000;
      mem_rdy  = 1'b1;
      alu_done = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         start = (k == 3) || (k == 7);
         reset = (k == 7);
      end
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      repeat (12) @(negedge clk);

      check("trace_queue_drained", 64'(exp_q.size()), 64'h0);
      check("latency_queue_drained", 64'(lat_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
